// File: rtl/vid_pattern_gen.sv
// vid_pattern_gen: programmable raster timing generator with a test-pattern
// engine, producing the receiver-style pixel bus (R[23:16], B[15:8], G[7:0]).
module vid_pattern_gen #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [1:0]  mode_i,
  output logic [23:0] data_o,
  output logic        vde_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [11:0] x_o,
  output logic [11:0] y_o,
  output logic        sof_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);

  // 13-bit thresholds so a sync window ending exactly at 4096 still compares correctly
  localparam logic [12:0] H_ACT_END = 13'(H_ACTIVE);
  localparam logic [12:0] V_ACT_END = 13'(V_ACTIVE);
  localparam logic [12:0] HS_START  = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END    = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VS_START  = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END    = 13'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [11:0] h_q, h_d;
  logic [11:0] v_q, v_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [11:0] bar_pix_q, bar_pix_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  frame_q, frame_d;
  logic [23:0] data_q, data_d;
  logic        vde_q, vde_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        sof_q, sof_d;

  logic        frame_start;
  logic        active;
  logic        hs_win;
  logic        vs_win;
  logic [1:0]  mode_cur;
  logic [23:0] pattern;

  // Decode the current counter position: active area, sync windows, frame start
  always_comb begin
    frame_start = (state_q == RUN) && (h_q == 12'd0) && (v_q == 12'd0);
    active      = ({1'b0, h_q} < H_ACT_END) && ({1'b0, v_q} < V_ACT_END);
    hs_win      = ({1'b0, h_q} >= HS_START) && ({1'b0, h_q} < HS_END);
    vs_win      = ({1'b0, v_q} >= VS_START) && ({1'b0, v_q} < VS_END);
    // the first pixel of a frame already uses the mode being latched for that frame
    mode_cur    = frame_start ? mode_i : mode_q;
  end

  // Pattern engine: pixel colour for the current position and frame mode
  always_comb begin
    pattern = 24'h000000;
    case (mode_cur)
      2'd0: begin
        case (bar_idx_q)
          3'd0:    pattern = 24'hFFFFFF;
          3'd1:    pattern = 24'hFF00FF;
          3'd2:    pattern = 24'h00FFFF;
          3'd3:    pattern = 24'h0000FF;
          3'd4:    pattern = 24'hFFFF00;
          3'd5:    pattern = 24'hFF0000;
          3'd6:    pattern = 24'h00FF00;
          default: pattern = 24'h000000;
        endcase
      end
      2'd1:    pattern = {3{h_q[7:0]}};
      2'd2:    pattern = (h_q[5] ^ v_q[5]) ? 24'hFFFFFF : 24'h000000;
      default: pattern = {3{frame_q}};
    endcase
  end

  // Next-state logic: FSM, raster counters, bar counter, mode/frame latches, output stage
  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    v_d       = v_q;
    bar_idx_d = bar_idx_q;
    bar_pix_d = bar_pix_q;
    mode_d    = mode_q;
    frame_d   = frame_q;

    data_d    = 24'h000000;
    vde_d     = 1'b0;
    hsync_d   = ~HS_POL;
    vsync_d   = ~VS_POL;
    x_d       = 12'd0;
    y_d       = 12'd0;
    sof_d     = 1'b0;

    case (state_q)
      IDLE: begin
        h_d       = 12'd0;
        v_d       = 12'd0;
        bar_idx_d = 3'd0;
        bar_pix_d = 12'd0;
        if (en_i) begin
          state_d = RUN;
        end
      end
      default: begin
        if (frame_start) begin
          mode_d = mode_i;
        end
        if (h_q == H_LAST) begin
          h_d       = 12'd0;
          bar_idx_d = 3'd0;
          bar_pix_d = 12'd0;
          if (v_q == V_LAST) begin
            v_d     = 12'd0;
            frame_d = frame_q + 8'd1;
            if (!en_i) begin
              state_d = IDLE;
            end
          end else begin
            v_d = v_q + 12'd1;
          end
        end else begin
          h_d = h_q + 12'd1;
          if (bar_pix_q == BAR_LAST) begin
            bar_pix_d = 12'd0;
            if (bar_idx_q != 3'd7) begin
              bar_idx_d = bar_idx_q + 3'd1;
            end
          end else begin
            bar_pix_d = bar_pix_q + 12'd1;
          end
        end

        data_d  = active ? pattern : 24'h000000;
        vde_d   = active;
        hsync_d = hs_win ? HS_POL : ~HS_POL;
        vsync_d = vs_win ? VS_POL : ~VS_POL;
        x_d     = h_q;
        y_d     = v_q;
        sof_d   = frame_start;
      end
    endcase
  end

  // State and output registers with asynchronous reset to the idle values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      h_q       <= 12'd0;
      v_q       <= 12'd0;
      bar_idx_q <= 3'd0;
      bar_pix_q <= 12'd0;
      mode_q    <= 2'd0;
      frame_q   <= 8'd0;
      data_q    <= 24'h000000;
      vde_q     <= 1'b0;
      hsync_q   <= ~HS_POL;
      vsync_q   <= ~VS_POL;
      x_q       <= 12'd0;
      y_q       <= 12'd0;
      sof_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      bar_idx_q <= bar_idx_d;
      bar_pix_q <= bar_pix_d;
      mode_q    <= mode_d;
      frame_q   <= frame_d;
      data_q    <= data_d;
      vde_q     <= vde_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sof_q     <= sof_d;
    end
  end

  assign data_o  = data_q;
  assign vde_o   = vde_q;
  assign hsync_o = hsync_q;
  assign vsync_o = vsync_q;
  assign x_o     = x_q;
  assign y_o     = y_q;
  assign sof_o   = sof_q;

endmodule

// File: tb/tb_vid_pattern_gen.sv
// tb_vid_pattern_gen: directed, table-driven bench for vid_pattern_gen using a
// small raster (H 16/2/3/3 -> 24 pixels, V 8/1/2/1 -> 12 lines, 288 per frame).
module tb_vid_pattern_gen;

  localparam int HT   = 24;
  localparam int FR   = 288;
  localparam int NCAP = 7 * FR + 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [23:0] data_o;
  logic        vde_o;
  logic        hsync_o;
  logic        vsync_o;
  logic [11:0] x_o;
  logic [11:0] y_o;
  logic        sof_o;

  vid_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en_i(en_i),
    .mode_i(mode_i),
    .data_o(data_o),
    .vde_o(vde_o),
    .hsync_o(hsync_o),
    .vsync_o(vsync_o),
    .x_o(x_o),
    .y_o(y_o),
    .sof_o(sof_o)
  );

  // 10 time-unit pixel clock
  always #5 clk = ~clk;

  typedef struct {
    int          frame;
    int          x;
    int          y;
    logic [23:0] data;
    logic        vde;
    logic        hs;
    logic        vs;
  } vec_t;

  vec_t vecs[$];

  int check_count = 0;
  int pass_count  = 0;

  logic [23:0] cap_data [NCAP];
  logic        cap_vde  [NCAP];
  logic        cap_hs   [NCAP];
  logic        cap_vs   [NCAP];
  logic        cap_sof  [NCAP];
  logic [11:0] cap_x    [NCAP];
  logic [11:0] cap_y    [NCAP];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic add_vec(input int f, input int x, input int y, input logic [23:0] d,
                         input logic vde, input logic hs, input logic vs);
    vec_t v;
    v.frame = f;
    v.x     = x;
    v.y     = y;
    v.data  = d;
    v.vde   = vde;
    v.hs    = hs;
    v.vs    = vs;
    vecs.push_back(v);
  endtask

  // Runs seven frames plus a short idle tail, changing mode mid-frame and
  // dropping en_i on line 3 of the last frame, capturing every output sample.
  task automatic apply_stimulus();
    for (int i = 0; i < NCAP; i++) begin
      step();
      cap_data[i] = data_o;
      cap_vde[i]  = vde_o;
      cap_hs[i]   = hsync_o;
      cap_vs[i]   = vsync_o;
      cap_sof[i]  = sof_o;
      cap_x[i]    = x_o;
      cap_y[i]    = y_o;
      if ((i % FR) == 100) begin
        case (i / FR)
          2: mode_i = 2'd1;
          3: mode_i = 2'd0;
          4: mode_i = 2'd2;
          default: ;
        endcase
      end
      if (i == 6 * FR + 72) begin
        en_i = 1'b0;
      end
    end
  endtask

  initial begin
    logic [23:0] bars [8];
    int          err_sof, err_vde, err_hs, err_vs, err_xy, err_idle, activity;
    int          vde_total, vs_total;

    bars[0] = 24'hFFFFFF; bars[1] = 24'hFF00FF; bars[2] = 24'h00FFFF; bars[3] = 24'h0000FF;
    bars[4] = 24'hFFFF00; bars[5] = 24'hFF0000; bars[6] = 24'h00FF00; bars[7] = 24'h000000;

    // frame, x, y, data, vde, hsync, vsync
    add_vec(0, 3, 2, 24'h000000, 1'b1, 1'b0, 1'b0);
    add_vec(1, 5, 5, 24'h010101, 1'b1, 1'b0, 1'b0);
    add_vec(2, 0, 7, 24'h020202, 1'b1, 1'b0, 1'b0);
    add_vec(2, 5, 6, 24'h020202, 1'b1, 1'b0, 1'b0);
    add_vec(3, 5, 0, 24'h050505, 1'b1, 1'b0, 1'b0);
    add_vec(3, 15, 7, 24'h0F0F0F, 1'b1, 1'b0, 1'b0);
    add_vec(3, 16, 0, 24'h000000, 1'b0, 1'b0, 1'b0);
    add_vec(3, 18, 3, 24'h000000, 1'b0, 1'b1, 1'b0);
    add_vec(3, 20, 9, 24'h000000, 1'b0, 1'b1, 1'b1);
    add_vec(3, 21, 9, 24'h000000, 1'b0, 1'b0, 1'b1);
    add_vec(3, 0, 9, 24'h000000, 1'b0, 1'b0, 1'b1);
    add_vec(3, 23, 10, 24'h000000, 1'b0, 1'b0, 1'b1);
    add_vec(3, 0, 11, 24'h000000, 1'b0, 1'b0, 1'b0);
    add_vec(3, 5, 8, 24'h000000, 1'b0, 1'b0, 1'b0);
    for (int x = 0; x < 16; x++) begin
      add_vec(4, x, 4, bars[x / 2], 1'b1, 1'b0, 1'b0);
    end
    add_vec(4, 16, 4, 24'h000000, 1'b0, 1'b0, 1'b0);
    add_vec(4, 1, 7, 24'hFFFFFF, 1'b1, 1'b0, 1'b0);
    add_vec(4, 15, 0, 24'h000000, 1'b1, 1'b0, 1'b0);
    add_vec(5, 3, 3, 24'h000000, 1'b1, 1'b0, 1'b0);
    add_vec(6, 5, 5, 24'h000000, 1'b1, 1'b0, 1'b0);
    add_vec(6, 23, 11, 24'h000000, 1'b0, 1'b0, 1'b0);

    // Reset values while reset is held
    repeat (3) step();
    check_output("reset data", 32'(data_o), 32'h0);
    check_output("reset vde", 32'(vde_o), 32'h0);
    check_output("reset hsync", 32'(hsync_o), 32'h0);
    check_output("reset vsync", 32'(vsync_o), 32'h0);
    check_output("reset x", 32'(x_o), 32'h0);
    check_output("reset y", 32'(y_o), 32'h0);
    check_output("reset sof", 32'(sof_o), 32'h0);

    // Released but not enabled: nothing moves
    reset = 1'b0;
    activity = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (vde_o || sof_o || x_o != 12'd0 || y_o != 12'd0) activity++;
    end
    check_output("idle before enable", 32'(activity), 32'h0);

    // Enable in grey mode; sof appears on the second edge after en_i is driven
    mode_i = 2'd3;
    en_i   = 1'b1;
    step();
    check_output("sof not after first edge", 32'(sof_o), 32'h0);
    apply_stimulus();
    check_output("first sof", 32'(cap_sof[0]), 32'h1);

    foreach (vecs[k]) begin
      int idx;
      idx = vecs[k].frame * FR + vecs[k].y * HT + vecs[k].x;
      check_output($sformatf("vec%0d data", k), 32'(cap_data[idx]), 32'(vecs[k].data));
      check_output($sformatf("vec%0d vde", k), 32'(cap_vde[idx]), 32'(vecs[k].vde));
      check_output($sformatf("vec%0d hsync", k), 32'(cap_hs[idx]), 32'(vecs[k].hs));
      check_output($sformatf("vec%0d vsync", k), 32'(cap_vs[idx]), 32'(vecs[k].vs));
      check_output($sformatf("vec%0d x", k), 32'(cap_x[idx]), 32'(vecs[k].x));
      check_output($sformatf("vec%0d y", k), 32'(cap_y[idx]), 32'(vecs[k].y));
    end

    // Whole-raster checks over the seven running frames
    err_sof = 0; err_vde = 0; err_hs = 0; err_vs = 0; err_xy = 0;
    vde_total = 0; vs_total = 0;
    for (int i = 0; i < 7 * FR; i++) begin
      int p, x, y;
      p = i % FR;
      x = p % HT;
      y = p / HT;
      if (cap_sof[i] !== (p == 0)) err_sof++;
      if (cap_vde[i] !== (x < 16 && y < 8)) err_vde++;
      if (cap_hs[i] !== (x >= 18 && x <= 20)) err_hs++;
      if (cap_vs[i] !== (y == 9 || y == 10)) err_vs++;
      if (cap_x[i] != 12'(x) || cap_y[i] != 12'(y)) err_xy++;
      if (!cap_vde[i] && cap_data[i] != 24'h0) err_vde++;
      if (cap_vde[i] === 1'b1) vde_total++;
      if (cap_vs[i] === 1'b1) vs_total++;
    end
    check_output("sof every 288 cycles errors", 32'(err_sof), 32'h0);
    check_output("vde window errors", 32'(err_vde), 32'h0);
    check_output("hsync window errors", 32'(err_hs), 32'h0);
    check_output("vsync window errors", 32'(err_vs), 32'h0);
    check_output("x/y counter errors", 32'(err_xy), 32'h0);
    check_output("active pixels over 7 frames", 32'(vde_total), 32'(7 * 128));
    check_output("vsync cycles over 7 frames", 32'(vs_total), 32'(7 * 48));

    // After the dropped frame completes, outputs sit at reset values
    err_idle = 0;
    for (int i = 7 * FR; i < NCAP; i++) begin
      if (cap_data[i] != 24'h0 || cap_vde[i] || cap_hs[i] || cap_vs[i] || cap_sof[i] ||
          cap_x[i] != 12'd0 || cap_y[i] != 12'd0) err_idle++;
    end
    check_output("idle after en_i drop", 32'(err_idle), 32'h0);

    // Restart from IDLE in gradient mode
    mode_i = 2'd1;
    en_i   = 1'b1;
    step();
    check_output("restart sof not after first edge", 32'(sof_o), 32'h0);
    step();
    check_output("restart sof", 32'(sof_o), 32'h1);
    check_output("restart x", 32'(x_o), 32'h0);
    check_output("restart y", 32'(y_o), 32'h0);
    repeat (5) step();
    check_output("restart x5 data", 32'(data_o), 32'h050505);
    check_output("restart x5 x", 32'(x_o), 32'h5);

    // Move to pixel (6,1) and assert reset mid-line
    repeat (25) step();
    check_output("pre-reset vde", 32'(vde_o), 32'h1);
    check_output("pre-reset data", 32'(data_o), 32'h060606);
    reset = 1'b1;
    en_i  = 1'b0;
    #1;
    check_output("async reset vde", 32'(vde_o), 32'h0);
    check_output("async reset data", 32'(data_o), 32'h0);
    check_output("async reset hsync", 32'(hsync_o), 32'h0);
    check_output("async reset vsync", 32'(vsync_o), 32'h0);
    check_output("async reset x", 32'(x_o), 32'h0);
    repeat (2) step();
    reset = 1'b0;
    activity = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (vde_o || sof_o || x_o != 12'd0 || y_o != 12'd0) activity++;
    end
    check_output("idle after reset release", 32'(activity), 32'h0);
    en_i = 1'b1;
    step();
    step();
    check_output("sof after reset restart", 32'(sof_o), 32'h1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
